// File: rtl/vend_pkg.sv
// +------------------------------------------------------------------+
// | vend_pkg : shared types and constants for the credit controller  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package vend_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_SUB    = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_BASE = 4'd10;

  function automatic logic bcd_code_ok(input logic [3:0] v);
    return (v != 4'd0) && (v <= BCD_MAX);
  endfunction
endpackage

`default_nettype wire

// File: rtl/bcd_digit_alu.sv
// +------------------------------------------------------------------+
// | bcd_digit_alu : one BCD digit add, or add nine's-complement      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bcd_digit_alu
  import vend_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    b_eff = sub ? (BCD_MAX - b) : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
    if (sum > {1'b0, BCD_MAX}) begin
      digit = 4'(sum - {1'b0, BCD_BASE});
      cout  = 1'b1;
    end else begin
      digit = sum[3:0];
      cout  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vend_credit_ctrl.sv
// +------------------------------------------------------------------+
// | vend_credit_ctrl : digit-serial BCD credit add/deduct/refund     |
// | Option macro: CREDIT_AUTO_REFUND_EN (offer change after vend)    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_valid,
  input  logic [3:0]        coin_val,
  output logic              coin_ready,
  output logic              coin_reject,
  input  logic [4*NDIG-1:0] price,
  input  logic              cancel,
  output logic [4*NDIG-1:0] credit,
  output logic              vend,
  output logic              refund_valid,
  output logic [4*NDIG-1:0] refund_val,
  input  logic              refund_ready,
  output logic              busy
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
`ifdef CREDIT_AUTO_REFUND_EN
  localparam logic AUTO_REFUND = 1'b1;
`else
  localparam logic AUTO_REFUND = 1'b0;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   credit_q, credit_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   refund_val_q, refund_val_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  bcd_t           coin_q, coin_d;
  logic           vend_q, vend_d;
  logic           reject_q, reject_d;
  logic           refund_valid_q, refund_valid_d;

  logic [W-1:0]   shadow_wr;
  bcd_t           alu_a, alu_b, alu_digit;
  logic           alu_cout, alu_sub, last_digit, price_nz;

  bcd_digit_alu u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .cin   (carry_q),
    .sub   (alu_sub),
    .digit (alu_digit),
    .cout  (alu_cout)
  );

  // The single ALU walks the digits; shadow_wr is the shadow with this cycle's digit merged in.
  always_comb begin
    alu_sub    = (state_q == ST_SUB);
    alu_a      = credit_q[{idx_q, 2'b00} +: 4];
    alu_b      = alu_sub ? price[{idx_q, 2'b00} +: 4] : ((idx_q == '0) ? coin_q : 4'd0);
    shadow_wr  = shadow_q;
    shadow_wr[{idx_q, 2'b00} +: 4] = alu_digit;
    last_digit = (idx_q == LAST_IDX);
    price_nz   = (price != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          if (credit_q != '0) state_d = ST_REFUND;
        end else if (coin_valid && bcd_code_ok(coin_val)) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD:    if (last_digit) state_d = alu_cout ? ST_IDLE : ST_SUB;
      ST_SUB:    if (last_digit) state_d = (alu_cout && price_nz && AUTO_REFUND && (shadow_wr != '0))
                                           ? ST_REFUND : ST_IDLE;
      ST_REFUND: if (refund_valid_q && refund_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_d       = credit_q;
    shadow_d       = shadow_q;
    refund_val_d   = refund_val_q;
    idx_d          = idx_q;
    carry_d        = carry_q;
    coin_d         = coin_q;
    vend_d         = 1'b0;
    reject_d       = 1'b0;
    refund_valid_d = refund_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          if (credit_q != '0) begin
            refund_val_d   = credit_q;
            refund_valid_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (bcd_code_ok(coin_val)) begin
            coin_d  = coin_val;
            idx_d   = '0;
            carry_d = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_ADD: begin
        shadow_d = shadow_wr;
        carry_d  = alu_cout;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          idx_d = '0;
          if (alu_cout) begin
            reject_d = 1'b1;
          end else begin
            credit_d = shadow_wr;
            carry_d  = 1'b1;
          end
        end
      end
      ST_SUB: begin
        shadow_d = shadow_wr;
        carry_d  = alu_cout;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          idx_d = '0;
          if (alu_cout && price_nz) begin
            credit_d = shadow_wr;
            vend_d   = 1'b1;
            if (AUTO_REFUND && (shadow_wr != '0)) refund_val_d = shadow_wr;
          end
        end
      end
      ST_REFUND: begin
        // After a vend the offer is raised one cycle late so it never overlaps the vend pulse.
        if (refund_valid_q && refund_ready) begin
          credit_d       = '0;
          refund_valid_d = 1'b0;
        end else begin
          refund_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q       <= '0;
      shadow_q       <= '0;
      refund_val_q   <= '0;
      idx_q          <= '0;
      carry_q        <= 1'b0;
      coin_q         <= 4'd0;
      vend_q         <= 1'b0;
      reject_q       <= 1'b0;
      refund_valid_q <= 1'b0;
    end else begin
      credit_q       <= credit_d;
      shadow_q       <= shadow_d;
      refund_val_q   <= refund_val_d;
      idx_q          <= idx_d;
      carry_q        <= carry_d;
      coin_q         <= coin_d;
      vend_q         <= vend_d;
      reject_q       <= reject_d;
      refund_valid_q <= refund_valid_d;
    end
  end

  always_comb begin
    coin_ready   = (state_q == ST_IDLE) && !cancel;
    busy         = (state_q != ST_IDLE);
    credit       = credit_q;
    vend         = vend_q;
    coin_reject  = reject_q;
    refund_valid = refund_valid_q;
    refund_val   = refund_val_q;
  end

endmodule

`default_nettype wire
